// File: rtl/fc1_sequencer.sv
// FC1 column sequencer: walks NUM_GROUP output-neuron groups, issues the
// input/weight/bias reads and broadcasts the phase code that the
// accumulate-bias-round columns decode, then holds each group's result
// on a valid/ready handshake until the consumer accepts it.
module fc1_sequencer #(
    parameter int NUM_GROUP = 4,
    parameter int GRP_W     = 2,
    parameter int W_AW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             res_ready,
    output logic [6:0]       in_count,
    output logic             in_rd_en,
    output logic [5:0]       in_addr,
    output logic             w_rd_en,
    output logic [W_AW-1:0]  w_addr,
    output logic             b_rd_en,
    output logic [GRP_W-1:0] b_addr,
    output logic             res_valid,
    output logic [GRP_W-1:0] res_group,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    // Phase codes and RUN counter landmarks
    localparam logic [6:0] CODE_IDLE = 7'd127;
    localparam logic [6:0] CODE_HOLD = 7'd67;
    localparam logic [6:0] CNT_NELEM = 7'd64;
    localparam logic [6:0] CNT_BIAS  = 7'd65;
    localparam logic [6:0] CNT_LAST  = 7'd68;
    localparam logic [6:0] CNT_PRE   = 7'd2;

    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUP - 1);
    localparam logic [GRP_W-1:0] GRP_ONE  = GRP_W'(1);

    state_t           state_q, state_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [6:0]       cnt_q, cnt_d;

    logic [6:0]       in_count_d;
    logic             in_rd_en_d, w_rd_en_d, b_rd_en_d;
    logic [5:0]       in_addr_d;
    logic [W_AW-1:0]  w_addr_d;
    logic [GRP_W-1:0] b_addr_d, res_group_d;
    logic             res_valid_d, busy_d, done_d;

    // State, group and phase counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: start only honoured in IDLE; HOLD exits on handshake
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    grp_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) state_d = HOLD;
                else                   cnt_d   = cnt_q + 7'd1;
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    if (grp_q == LAST_GRP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        grp_d   = grp_q + GRP_ONE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output comes off a flop
    // yet lines up with the state it describes
    always_comb begin
        in_count_d  = CODE_IDLE;
        in_rd_en_d  = 1'b0;
        in_addr_d   = '0;
        w_rd_en_d   = 1'b0;
        w_addr_d    = '0;
        b_rd_en_d   = 1'b0;
        b_addr_d    = '0;
        res_valid_d = 1'b0;
        res_group_d = '0;
        busy_d      = 1'b0;
        case (state_d)
            RUN: begin
                busy_d = 1'b1;
                if (cnt_d < CNT_NELEM) begin
                    in_rd_en_d = 1'b1;
                    w_rd_en_d  = 1'b1;
                    in_addr_d  = cnt_d[5:0];
                    w_addr_d   = {grp_d, cnt_d[5:0]};
                end
                if (cnt_d == CNT_BIAS) begin
                    b_rd_en_d = 1'b1;
                    b_addr_d  = grp_d;
                end
                // Two leading idle codes flush column sums and products
                // while the first operands travel through memory
                if (cnt_d >= CNT_PRE) in_count_d = cnt_d - CNT_PRE;
            end
            HOLD: begin
                busy_d      = 1'b1;
                in_count_d  = CODE_HOLD;
                res_valid_d = 1'b1;
                res_group_d = grp_d;
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_count  <= CODE_IDLE;
            in_rd_en  <= 1'b0;
            in_addr   <= '0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            b_rd_en   <= 1'b0;
            b_addr    <= '0;
            res_valid <= 1'b0;
            res_group <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_count  <= in_count_d;
            in_rd_en  <= in_rd_en_d;
            in_addr   <= in_addr_d;
            w_rd_en   <= w_rd_en_d;
            w_addr    <= w_addr_d;
            b_rd_en   <= b_rd_en_d;
            b_addr    <= b_addr_d;
            res_valid <= res_valid_d;
            res_group <= res_group_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_fc1_sequencer.sv
// Bench for fc1_sequencer: the DUT drives behavioural memories and one
// accumulate-bias-round column, so both the control timing and the
// end-to-end column result are checked against hand-computed values.
module tb_fc1_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, res_ready;
    logic [6:0] in_count;
    logic       in_rd_en, w_rd_en, b_rd_en;
    logic [5:0] in_addr;
    logic [7:0] w_addr;
    logic [1:0] b_addr, res_group;
    logic       res_valid, busy, done;

    fc1_sequencer #(.NUM_GROUP(4), .GRP_W(2), .W_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .res_ready(res_ready),
        .in_count(in_count), .in_rd_en(in_rd_en), .in_addr(in_addr),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .b_rd_en(b_rd_en), .b_addr(b_addr),
        .res_valid(res_valid), .res_group(res_group), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Memories (1-cycle read latency) and one column
    int inbuf [64];
    int wmem  [256];
    int bmem  [4];
    int in_q = 0, w_q = 0, b_q = 0;
    int d_r = 0, w_r = 0, b_r = 0, prod = 0, sum = 0;

    function automatic int rne8(input int s);
        int q, f;
        q = s >>> 8;
        f = s & 255;
        if (f > 128 || (f == 128 && q[0])) q = q + 1;
        return q;
    endfunction

    always @(posedge clk) begin
        in_q <= in_rd_en ? inbuf[in_addr] : 0;
        w_q  <= w_rd_en  ? wmem[w_addr]   : 0;
        b_q  <= b_rd_en  ? bmem[b_addr]   : 0;
    end

    always @(posedge clk) begin
        d_r <= in_q;
        w_r <= w_q;
        b_r <= b_q;
        if (in_count >= 7'd68) begin
            prod <= 0;
            sum  <= 0;
        end else begin
            prod <= d_r * w_r;
            if (in_count <= 7'd64)      sum <= sum + prod;
            else if (in_count == 7'd65) sum <= sum + (b_r <<< 8);
            else if (in_count == 7'd66) sum <= rne8(sum);
        end
    end

    // Read-order monitor: weight reads must run 0..255 with in_addr as low bits
    logic mon_clr = 1'b0;
    int   w_idx = 0, w_bad = 0;
    always @(negedge clk) begin
        if (mon_clr) begin
            w_idx <= 0;
            w_bad <= 0;
        end else if (w_rd_en) begin
            if (int'(w_addr) != w_idx || int'(in_addr) != (w_idx % 64)) w_bad <= w_bad + 1;
            w_idx <= w_idx + 1;
        end
    end

    int hs_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        if (res_valid && res_ready) hs_cnt   <= hs_cnt + 1;
        if (done)                   done_cnt <= done_cnt + 1;
    end

    // Per-group column data: inputs all 1; expected rounded sum
    typedef struct { int w; int b; int exp; } colvec_t;
    colvec_t colv [4];

    // Timing vectors relative to start cycle S; -1 means don't care
    typedef struct {
        string nm; int off;
        int ic; int ird; int iad; int brd; int bad; int rv; int rg; int bsy; int dn;
        int col;  // -9999: column not checked
    } tvec_t;
    localparam int NTV = 16;
    tvec_t tv [NTV];

    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int s, s2, s3, s4, hs0, d0, rvc;

        // 64*512 = 128<<8, plus 3<<8 -> 131; 0x180 -> 2; 0x280 -> 2; -0x180 -> -2
        colv[0] = '{512, 3, 131};
        colv[1] = '{6, 0, 2};
        colv[2] = '{10, 0, 2};
        colv[3] = '{-6, 0, -2};
        for (int i = 0; i < 64; i++) inbuf[i] = 1;
        for (int g = 0; g < 4; g++) begin
            bmem[g] = colv[g].b;
            for (int e = 0; e < 64; e++) wmem[g*64 + e] = colv[g].w;
        end

        //            name        off  ic  ird iad brd bad rv  rg  bsy dn  col
        tv[0]  = '{"cnt0",        1, 127, 1,  0,  0, -1, 0, -1, 1, 0, -9999};
        tv[1]  = '{"cnt1",        2, 127, 1,  1,  0, -1, 0, -1, 1, 0, -9999};
        tv[2]  = '{"ic0",         3,   0, 1,  2,  0, -1, 0, -1, 1, 0, -9999};
        tv[3]  = '{"cnt63",      64,  61, 1, 63,  0, -1, 0, -1, 1, 0, -9999};
        tv[4]  = '{"cnt64",      65,  62, 0, -1,  0, -1, 0, -1, 1, 0, -9999};
        tv[5]  = '{"bias_rd0",   66,  63, 0, -1,  1,  0, 0, -1, 1, 0, -9999};
        tv[6]  = '{"ic65",       68,  65, 0, -1,  0, -1, 0, -1, 1, 0, -9999};
        tv[7]  = '{"ic66",       69,  66, 0, -1,  0, -1, 0, -1, 1, 0, -9999};
        tv[8]  = '{"hold0",      70,  67, 0, -1,  0, -1, 1,  0, 1, 0, 131};
        tv[9]  = '{"grp1_cnt0",  71, 127, 1,  0,  0, -1, 0, -1, 1, 0, -9999};
        tv[10] = '{"hold1",     140,  67, 0, -1,  0, -1, 1,  1, 1, 0, 2};
        tv[11] = '{"bias_rd2",  206,  63, 0, -1,  1,  2, 0, -1, 1, 0, -9999};
        tv[12] = '{"hold2",     210,  67, 0, -1,  0, -1, 1,  2, 1, 0, 2};
        tv[13] = '{"hold3",     280,  67, 0, -1,  0, -1, 1,  3, 1, 0, -2};
        tv[14] = '{"done",      281, 127, 0, -1,  0, -1, 0, -1, 0, 1, -9999};
        tv[15] = '{"idle",      282, 127, 0, -1,  0, -1, 0, -1, 0, 0, -9999};

        rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.in_count", in_count, 127);
        chk("rst.in_rd_en", in_rd_en, 0);
        chk("rst.in_addr", in_addr, 0);
        chk("rst.w_rd_en", w_rd_en, 0);
        chk("rst.w_addr", w_addr, 0);
        chk("rst.b_rd_en", b_rd_en, 0);
        chk("rst.b_addr", b_addr, 0);
        chk("rst.res_valid", res_valid, 0);
        chk("rst.res_group", res_group, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pass 1: full four-group pass, ready high, stray starts while busy
        // and on the final handshake cycle
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        hs0 = hs_cnt;
        d0  = done_cnt;
        pulse_start(s);
        fork
            begin
                for (int i = 0; i < NTV; i++) begin
                    wait_cyc(s + tv[i].off);
                    chk({tv[i].nm, ".in_count"}, in_count, tv[i].ic);
                    chk({tv[i].nm, ".in_rd_en"}, in_rd_en, tv[i].ird);
                    if (tv[i].iad >= 0) chk({tv[i].nm, ".in_addr"}, in_addr, tv[i].iad);
                    chk({tv[i].nm, ".b_rd_en"}, b_rd_en, tv[i].brd);
                    if (tv[i].bad >= 0) chk({tv[i].nm, ".b_addr"}, b_addr, tv[i].bad);
                    chk({tv[i].nm, ".res_valid"}, res_valid, tv[i].rv);
                    if (tv[i].rg >= 0) chk({tv[i].nm, ".res_group"}, res_group, tv[i].rg);
                    chk({tv[i].nm, ".busy"}, busy, tv[i].bsy);
                    chk({tv[i].nm, ".done"}, done, tv[i].dn);
                    if (tv[i].col != -9999) chk({tv[i].nm, ".col_sum"}, sum, tv[i].col);
                end
            end
            begin
                wait_cyc(s + 20);  start = 1'b1; @(negedge clk); start = 1'b0;
                wait_cyc(s + 150); start = 1'b1; @(negedge clk); start = 1'b0;
                wait_cyc(s + 280); start = 1'b1; @(negedge clk); start = 1'b0;
            end
        join
        wait_cyc(s + 285);
        chk("p1.w_reads", w_idx, 256);
        chk("p1.w_addr_seq_errs", w_bad, 0);
        chk("p1.handshakes", hs_cnt - hs0, 4);
        chk("p1.done_pulses", done_cnt - d0, 1);
        chk("p1.stays_idle", busy, 0);

        // Pass 2: res_ready low for 5 cycles while group 1 is held
        hs0 = hs_cnt;
        pulse_start(s2);
        rvc = 0;
        for (int c = s2 + 139; c <= s2 + 147; c++) begin
            wait_cyc(c);
            if (res_valid) rvc++;
            if (c == s2 + 139) res_ready = 1'b0;
            if (c == s2 + 142) begin
                chk("bp.in_count", in_count, 67);
                chk("bp.res_valid", res_valid, 1);
                chk("bp.col_sum_mid", sum, 2);
            end
            if (c == s2 + 145) begin
                chk("bp.res_group", res_group, 1);
                chk("bp.col_sum_end", sum, 2);
                res_ready = 1'b1;
            end
            if (c == s2 + 146) chk("bp.next_grp_cnt0", in_count, 127);
        end
        chk("bp.valid_cycles", rvc, 6);
        wait_cyc(s2 + 215);
        chk("bp.grp2_col_sum", sum, 2);
        wait_cyc(s2 + 281);
        chk("bp.no_early_done", done, 0);
        chk("bp.busy_at_281", busy, 1);
        wait_cyc(s2 + 286);
        chk("bp.done_delayed", done, 1);
        chk("bp.handshakes", hs_cnt - hs0, 4);

        // Pass 3: reset at RUN cnt=30 of group 2
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        pulse_start(s3);
        wait_cyc(s3 + 171);
        chk("rr.in_addr_before", in_addr, 30);
        chk("rr.in_count_before", in_count, 28);
        rst_n = 1'b0;
        #1;
        chk("rr.in_count", in_count, 127);
        chk("rr.in_rd_en", in_rd_en, 0);
        chk("rr.w_rd_en", w_rd_en, 0);
        chk("rr.b_rd_en", b_rd_en, 0);
        chk("rr.busy", busy, 0);
        chk("rr.res_valid", res_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rr.no_done", done_cnt - d0, 0);
        chk("rr.idle_after", busy, 0);

        // Fresh start after reset begins at group 0
        pulse_start(s4);
        chk("rs.in_addr", in_addr, 0);
        chk("rs.in_rd_en", in_rd_en, 1);
        wait_cyc(s4 + 66);
        chk("rs.b_addr", b_addr, 0);
        wait_cyc(s4 + 70);
        chk("rs.res_group", res_group, 0);
        chk("rs.col_sum", sum, 131);
        wait_cyc(s4 + 281);
        chk("rs.done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
